// File: rtl/cnt8.sv
// -----------------------------------------------------------------------------
// cnt8 -- 8-bit loadable up-counter with carry-in / carry-out.
//
// Optional feature: define CNT8_SCLR_EN to add a synchronous clear input
// (clr). Clear has the highest priority among the synchronous controls.
//
// Ports
//   clk  in   1  rising-edge clock
//   rst  in   1  asynchronous active-low reset; q is forced to 8'h00
//   clr  in   1  synchronous clear (only with CNT8_SCLR_EN)
//   ld   in   1  synchronous parallel load of d; wins over counting
//   d    in   8  parallel-load data
//   ci   in   1  carry-in / count enable
//   co   out  1  carry-out = ci & (q == 8'hFF), combinational
//   q    out  8  registered counter value
// -----------------------------------------------------------------------------
module cnt8 (
  input  logic       clk,
  input  logic       rst,
`ifdef CNT8_SCLR_EN
  input  logic       clr,
`endif
  input  logic       ld,
  input  logic [7:0] d,
  input  logic       ci,
  output logic       co,
  output logic [7:0] q
);

  logic [7:0] q_d;
  logic [7:0] q_q;
  logic       sclr;

`ifdef CNT8_SCLR_EN
  assign sclr = clr;
`else
  // Without the clear feature the clear term is tied inactive.
  assign sclr = 1'b0;
`endif

  // Next-state selection: clear > load > increment > hold.
  always_comb begin
    q_d = q_q;
    if (sclr) begin
      q_d = 8'h00;
    end else if (ld) begin
      q_d = d;
    end else if (ci) begin
      // 8-bit addition wraps 8'hFF to 8'h00 naturally.
      q_d = q_q + 8'h01;
    end else begin
      q_d = q_q;
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

  // Carry-out looks at the current register value only, so it is independent
  // of ld and is 0 during reset because q_q is held at 8'h00.
  assign co = ci & (q_q == 8'hFF);

endmodule

// File: tb/tb_cnt8.sv
// -----------------------------------------------------------------------------
// tb_cnt8 -- self-checking bench for cnt8.
// The reference is an integer counter value updated with plain modulo-256
// arithmetic from the load/count/clear rules; co is predicted from it.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cnt8;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       ld;
  logic [7:0] d;
  logic       ci;
  logic       co;
  logic [7:0] q;

  int total;
  int bad;
  int m;      // reference counter value, 0..255

  cnt8 dut (
    .clk (clk),
    .rst (rst),
`ifdef CNT8_SCLR_EN
    .clr (clr),
`endif
    .ld  (ld),
    .d   (d),
    .ci  (ci),
    .co  (co),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit exp_co(input logic ci_v, input int mv);
    return (ci_v === 1'b1) && (mv == 255);
  endfunction

  // Apply inputs just after an edge, take one rising edge, update the model,
  // and leave time 1 ns after the edge for sampling.
  task automatic cyc(input logic ld_v, input logic [7:0] d_v, input logic ci_v,
                     input logic clr_v);
    ld  = ld_v;
    d   = d_v;
    ci  = ci_v;
`ifdef CNT8_SCLR_EN
    clr = clr_v;
`else
    clr = 1'b0;
`endif
    @(posedge clk);
    if (clr === 1'b1)  m = 0;
    else if (ld_v)     m = d_v;
    else if (ci_v)     m = (m + 1) % 256;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0; d = 8'h00; ci = 1'b1; clr = 1'b0;
    #7 rst = 1'b0;
    #1;
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_async_q: got %h want 00", q); end
    total++;
    if (co !== 1'b0) begin bad++; $display("FAIL reset_co: got %b want 0", co); end
    // Hold reset across the edge at 15 with load requested: must be ignored.
    ld = 1'b1; d = 8'hC3;
    #14;      // t=22, edge at 15 passed
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_hold_q: got %h want 00", q); end
    ld = 1'b0;
    rst = 1'b1;
    m = 0;
    @(posedge clk); #1;   // edge at 25
    m = (m + 1) % 256;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (q !== m[7:0]) begin bad++; $display("FAIL reset_then_count[%0d]: got %h want %h", i, q, m[7:0]); end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
  endtask

  task automatic test_load_wrap();
    cyc(1'b1, 8'hFE, 1'b0, 1'b0);
    total++;
    if (q !== 8'hFE || co !== 1'b0) begin bad++; $display("FAIL load_fe: got q=%h co=%b want q=fe co=0", q, co); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (q !== 8'hFF || co !== 1'b1) begin bad++; $display("FAIL inc_ff: got q=%h co=%b want q=ff co=1", q, co); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (q !== 8'h00 || co !== 1'b0) begin bad++; $display("FAIL wrap_00: got q=%h co=%b want q=00 co=0", q, co); end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (q !== 8'h01) begin bad++; $display("FAIL wrap_01: got %h want 01", q); end
  endtask

  task automatic test_co_toggle();
    cyc(1'b1, 8'hFF, 1'b1, 1'b0);   // load FF with ci=1: co asserts from this edge
    total++;
    if (q !== 8'hFF || co !== 1'b1) begin bad++; $display("FAIL load_ff_co: got q=%h co=%b want q=ff co=1", q, co); end
    ld = 1'b0; ci = 1'b0;
    #1;
    total++;
    if (co !== 1'b0) begin bad++; $display("FAIL co_follows_ci: got %b want 0", co); end
    ld = 1'b1; ci = 1'b1;            // co must not depend on ld
    #1;
    total++;
    if (co !== 1'b1) begin bad++; $display("FAIL co_ignores_ld: got %b want 1", co); end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    total++;
    if (q !== 8'hFF || co !== 1'b0) begin bad++; $display("FAIL hold_ff: got q=%h co=%b want q=ff co=0", q, co); end
  endtask

  task automatic test_load_priority();
    cyc(1'b1, 8'h5A, 1'b1, 1'b0);
    total++;
    if (q !== 8'h5A) begin bad++; $display("FAIL load_beats_ci: got %h want 5a", q); end
  endtask

  task automatic test_glitch();
    // Pulse inputs between edges; only the values at the edge matter.
    ld = 1'b0; ci = 1'b0; d = 8'h00;
    #1 ld = 1'b1; d = 8'h99; ci = 1'b1;
    #2 ld = 1'b0; ci = 1'b0;
    @(posedge clk); #1;
    total++;
    if (q !== m[7:0]) begin bad++; $display("FAIL glitch_ignored: got %h want %h", q, m[7:0]); end
  endtask

  task automatic test_midcount_reset();
    cyc(1'b1, 8'h40, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    ci = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL midcount_reset: got %h want 00", q); end
    @(posedge clk); #2;
    rst = 1'b1;
    m = 0;
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    total++;
    if (q !== 8'h01) begin bad++; $display("FAIL after_midreset: got %h want 01", q); end
  endtask

  task automatic test_clear();
`ifdef CNT8_SCLR_EN
    cyc(1'b1, 8'h37, 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, 1'b1);
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL clr_overrides: got %h want 00", q); end
    clr = 1'b0;
`endif
  endtask

  task automatic test_random();
    logic       r_ld;
    logic       r_ci;
    logic [7:0] r_d;
    for (int i = 0; i < 400; i++) begin
      r_ld = ($urandom_range(0, 7) == 0);
      r_ci = ($urandom_range(0, 3) != 0);
      r_d  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom_range(0, 255));
      ld = r_ld; d = r_d; ci = r_ci;
      #1;
      total++;
      if (co !== exp_co(r_ci, m)) begin
        bad++; $display("FAIL rand_co[%0d]: got %b want %b (q=%h)", i, co, exp_co(r_ci, m), q);
      end
      cyc(r_ld, r_d, r_ci, 1'b0);
      total++;
      if (q !== m[7:0]) begin bad++; $display("FAIL rand_q[%0d]: got %h want %h", i, q, m[7:0]); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    m     = 0;
    test_reset();
    test_load_wrap();
    test_co_toggle();
    test_load_priority();
    test_glitch();
    test_midcount_reset();
    test_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt8.md
CNT8 -- requirements
Module: cnt8

Interface
- REQ-001 No parameters; data width fixed at 8 bits.
- REQ-002 clk  input  1  single clock; all state changes on rising edge except reset.
- REQ-003 rst  input  1  asynchronous, active-low reset.
- REQ-004 ld  input  1  synchronous parallel-load enable.
- REQ-005 d  input  8  parallel-load data.
- REQ-006 ci  input  1  carry-in / count enable.
- REQ-007 co  output  1  carry-out, combinational.
- REQ-008 q  output  8  counter value, registered.
- REQ-009 clr  input  1  synchronous clear; present only when CNT8_SCLR_EN is defined.

Function
- REQ-010 Per rising clk with rst=1, priority: clr (if compiled in) > ld > ci > hold.
- REQ-011 ld=1: q <= d on that edge, regardless of ci; no increment in the same cycle.
- REQ-012 ld=0, ci=1: q <= q+1 modulo 256; 8'hFF wraps to 8'h00.
- REQ-013 ld=0, ci=0: q holds.
- REQ-014 co = ci & (q == 8'hFF), purely combinational; it does not depend on ld.
- REQ-015 co is 0 whenever ci=0, including when q=8'hFF.
- REQ-016 Latency: a load or increment is visible on q one clock edge after the inputs are sampled; co follows ci and q with zero cycles of latency.
- REQ-017 Inputs are sampled only at the rising edge; glitches between edges have no effect on q.
- REQ-018 Loading 8'hFF with ci=1 asserts co combinationally from the edge that loads it.

Reset
- REQ-019 rst=0 forces q to 8'h00 immediately, with no clock required; co is then 0 regardless of ci.
- REQ-020 While rst=0, q holds 8'h00 and ld, d, ci and clr are ignored.
- REQ-021 After rst deasserts, the first rising edge operates normally per REQ-010.
- REQ-022 Reset asserted mid-count or during a load aborts that operation; q goes to 8'h00.

Configuration
- REQ-023 Macro CNT8_SCLR_EN defined: port clr exists; clr=1 at a rising edge sets q <= 8'h00, overriding ld and ci.
- REQ-024 CNT8_SCLR_EN undefined: no clr port; behaviour is exactly REQ-010..REQ-022 without clear.

Verification
- REQ-025 Pulse rst low at t=5..15 with ld=0, ci=1 -> q=8'h00 asynchronously, then increments 01, 02, ... on each following rising edge.
- REQ-026 ld=1, d=8'hFE, ci=0 for one edge -> q=8'hFE next cycle, co=0.
- REQ-027 From q=8'hFE, ld=0, ci=1 -> q=8'hFF with co=1, next edge q=8'h00 with co=0, then 8'h01.
- REQ-028 q=8'hFF, ci toggled 1->0 -> co follows ci combinationally (1->0) and q holds at 8'hFF.
- REQ-029 ld=1, d=8'h5A, ci=1 simultaneously -> q=8'h5A (load wins, no increment).
- REQ-030 With CNT8_SCLR_EN defined: q=8'h37, clr=1, ld=1, d=8'hAA -> q=8'h00 next edge; assert rst=0 mid-count -> q=8'h00 before the next clk edge.
